// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared types and default timing constants for the pong game sequencer
package pong_pkg;

    localparam int SCORE_W = 4;
    localparam int CNT_W   = 26;

    localparam logic [SCORE_W-1:0] WIN_SCORE_DEF    = 4'd9;
    localparam logic [CNT_W-1:0]   SERVE_CYCLES_DEF = 26'd50_000_000;
    localparam logic [15:0]        CLEAR_CYCLES_DEF = 16'd1000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_SERVE,
        ST_PLAY,
        ST_PAUSE,
        ST_OVER
    } game_state_t;

    function automatic logic score_wins(input logic [SCORE_W-1:0] score,
                                        input logic [SCORE_W-1:0] win_score);
        return score >= win_score;
    endfunction

endpackage

// File: rtl/button_sync.sv
// rtl/button_sync.sv - two-flop synchroniser with a one-cycle rising-edge pulse
module button_sync (
    input  logic clock,
    input  logic resetn,
    input  logic btn,
    output logic pulse
);

    logic sync0;
    logic sync1;
    logic sync1_d;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync0   <= 1'b0;
            sync1   <= 1'b0;
            sync1_d <= 1'b0;
        end else begin
            sync0   <= btn;
            sync1   <= sync0;
            sync1_d <= sync1;
        end
    end

    // A held button only ever yields one pulse: the edge detector needs a low to re-arm.
    assign pulse = sync1 & ~sync1_d;

endmodule

// File: rtl/pong_game_ctrl.sv
// rtl/pong_game_ctrl.sv - pong game sequencer (start/serve/play/over); pause path under PONG_PAUSE_EN
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter logic [SCORE_W-1:0] WIN_SCORE    = WIN_SCORE_DEF,
    parameter logic [CNT_W-1:0]   SERVE_CYCLES = SERVE_CYCLES_DEF,
    parameter logic [15:0]        CLEAR_CYCLES = CLEAR_CYCLES_DEF
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic               startBtn,
    input  logic               pauseBtn,
    input  logic [SCORE_W-1:0] p0_score,
    input  logic [SCORE_W-1:0] p1_score,
    output logic               inPlay,
    output logic               newGame,
    output logic               paused,
    output logic               gameOver,
    output logic               winner
);

    localparam logic [CNT_W-1:0] CLEAR_LOAD = {{(CNT_W-16){1'b0}}, CLEAR_CYCLES - 16'd1};
    localparam logic [CNT_W-1:0] SERVE_LOAD = SERVE_CYCLES - CNT_W'(1);

    game_state_t        state_q;
    game_state_t        state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;

    logic               start_pulse;
    logic               pause_pulse;

    logic [SCORE_W-1:0] p0_sync0, p0_sync1, p0_prev;
    logic [SCORE_W-1:0] p1_sync0, p1_sync1, p1_prev;
    logic               score_evt;
    logic               win_hit;

    button_sync u_start_sync (
        .clock  (clock),
        .resetn (resetn),
        .btn    (startBtn),
        .pulse  (start_pulse)
    );

`ifdef PONG_PAUSE_EN
    button_sync u_pause_sync (
        .clock  (clock),
        .resetn (resetn),
        .btn    (pauseBtn),
        .pulse  (pause_pulse)
    );
`else
    logic unused_pause_btn;
    assign unused_pause_btn = pauseBtn;
    assign pause_pulse      = 1'b0;
`endif

    // Scores come from the dynamics clock domain; prev tracks every cycle so
    // changes outside PLAY (e.g. the clear) are absorbed without a transition.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            p0_sync0 <= '0;
            p0_sync1 <= '0;
            p0_prev  <= '0;
            p1_sync0 <= '0;
            p1_sync1 <= '0;
            p1_prev  <= '0;
        end else begin
            p0_sync0 <= p0_score;
            p0_sync1 <= p0_sync0;
            p0_prev  <= p0_sync1;
            p1_sync0 <= p1_score;
            p1_sync1 <= p1_sync0;
            p1_prev  <= p1_sync1;
        end
    end

    assign score_evt = (p0_sync1 != p0_prev) || (p1_sync1 != p1_prev);
    assign win_hit   = score_wins(p0_sync1, WIN_SCORE) || score_wins(p1_sync1, WIN_SCORE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_pulse) state_d = ST_CLEAR;
            ST_CLEAR: if (cnt_q == '0) state_d = ST_SERVE;
            ST_SERVE: if (cnt_q == '0) state_d = ST_PLAY;
            ST_PLAY: begin
                if (score_evt) begin
                    state_d = win_hit ? ST_OVER : ST_SERVE;
                end else if (pause_pulse) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: if (pause_pulse) state_d = ST_PLAY;
            ST_OVER:  if (start_pulse) state_d = ST_CLEAR;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d = '0;
        if (state_d != state_q) begin
            if (state_d == ST_CLEAR) begin
                cnt_d = CLEAR_LOAD;
            end else if (state_d == ST_SERVE) begin
                cnt_d = SERVE_LOAD;
            end
        end else if ((state_q == ST_CLEAR || state_q == ST_SERVE) && cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Outputs decode the next state so they switch together with state_q.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            inPlay   <= 1'b0;
            newGame  <= 1'b0;
            paused   <= 1'b0;
            gameOver <= 1'b0;
            winner   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            inPlay   <= (state_d == ST_PLAY);
            newGame  <= (state_d == ST_CLEAR);
`ifdef PONG_PAUSE_EN
            paused   <= (state_d == ST_PAUSE);
`else
            paused   <= 1'b0;
`endif
            gameOver <= (state_d == ST_OVER);
            if (state_d == ST_OVER && state_q != ST_OVER) begin
                winner <= score_wins(p1_sync1, WIN_SCORE);
            end
        end
    end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// tb/tb_pong_game_ctrl.sv - randomized scoreboard bench for pong_game_ctrl
module tb_pong_game_ctrl;

    localparam int SERVE = 20;
    localparam int CLR   = 5;
    localparam int WIN   = 9;
`ifdef PONG_PAUSE_EN
    localparam bit PAUSE_EN = 1'b1;
`else
    localparam bit PAUSE_EN = 1'b0;
`endif

    localparam int M_IDLE  = 0;
    localparam int M_CLEAR = 1;
    localparam int M_SERVE = 2;
    localparam int M_PLAY  = 3;
    localparam int M_PAUSE = 4;
    localparam int M_OVER  = 5;

    logic       clock    = 1'b0;
    logic       resetn   = 1'b0;
    logic       startBtn = 1'b0;
    logic       pauseBtn = 1'b0;
    logic [3:0] p0_score = 4'd0;
    logic [3:0] p1_score = 4'd0;
    logic       inPlay, newGame, paused, gameOver, winner;

    pong_game_ctrl #(
        .WIN_SCORE    (4'd9),
        .SERVE_CYCLES (26'd20),
        .CLEAR_CYCLES (16'd5)
    ) dut (
        .clock    (clock),
        .resetn   (resetn),
        .startBtn (startBtn),
        .pauseBtn (pauseBtn),
        .p0_score (p0_score),
        .p1_score (p1_score),
        .inPlay   (inPlay),
        .newGame  (newGame),
        .paused   (paused),
        .gameOver (gameOver),
        .winner   (winner)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int         at;
        logic [4:0] v;
    } ev_t;

    ev_t        q[$];
    int         checks   = 0;
    int         failures = 0;
    int         mode     = M_IDLE;
    logic       w        = 1'b0;
    int         last_ev  = 0;
    int         score[2] = '{0, 0};
    int         now      = 0;
    bit         mon_en   = 1'b0;
    logic [4:0] last_v   = 5'd0;
    logic [4:0] mon_v;
    ev_t        e;

    // Output vector order: {inPlay, newGame, paused, gameOver, winner}
    function automatic logic [4:0] outs_of(input int m, input logic win);
        return {m == M_PLAY, m == M_CLEAR, m == M_PAUSE, m == M_OVER, win};
    endfunction

    task automatic go(input int at, input int m);
        mode = m;
        q.push_back(ev_t'{at, outs_of(m, w)});
        last_ev = at;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
        now = cyc;
    endtask

    task automatic settle();
        while (now <= last_ev + 3) step(1);
    endtask

    task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%b want=%b at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic press(input bit st, input bit pa, input int hold, input bit clr);
        int  c;
        bit  accepted;
        int  len;
        c        = now;
        accepted = 1'b0;
        startBtn = st;
        pauseBtn = pa;
        if (st && (mode == M_IDLE || mode == M_OVER)) begin
            go(c + 3, M_CLEAR);
            go(c + 3 + CLR, M_SERVE);
            go(c + 3 + CLR + SERVE, M_PLAY);
            accepted = 1'b1;
        end else if (pa && PAUSE_EN && mode == M_PLAY) begin
            go(c + 3, M_PAUSE);
        end else if (pa && PAUSE_EN && mode == M_PAUSE) begin
            go(c + 3, M_PLAY);
        end
        len = (hold > 5) ? hold : 5;
        for (int i = 1; i <= len; i++) begin
            step(1);
            if (i == hold) begin
                startBtn = 1'b0;
                pauseBtn = 1'b0;
            end
            if (i == 4 && clr && accepted) begin
                score[0] = 0;
                score[1] = 0;
                p0_score = 4'd0;
                p1_score = 4'd0;
            end
        end
        step(5);
    endtask

    task automatic point(input int p, input bit with_pause, input bit poke);
        int c;
        int k;
        c = now;
        score[p]++;
        if (p == 0) p0_score = 4'(score[0]);
        else        p1_score = 4'(score[1]);
        if (with_pause) pauseBtn = 1'b1;
        if (score[p] >= WIN) begin
            w = p[0];
            go(c + 3, M_OVER);
        end else begin
            go(c + 3, M_SERVE);
            go(c + 3 + SERVE, M_PLAY);
        end
        if (with_pause) begin
            step($urandom_range(1, 2));
            pauseBtn = 1'b0;
        end
        if (poke && score[p] < WIN) begin
            k = $urandom_range(0, 15);
            while (now < c + 3 + k) step(1);
            if ($urandom_range(0, 1) == 1) startBtn = 1'b1;
            else                           pauseBtn = 1'b1;
            step($urandom_range(1, 3));
            startBtn = 1'b0;
            pauseBtn = 1'b0;
        end
        settle();
    endtask

    task automatic async_reset(input string name);
        #1;
        resetn = 1'b0;
        q.delete();
        if (outs_of(mode, w) != 5'd0) begin
            q.push_back(ev_t'{now, 5'd0});
        end
        mode    = M_IDLE;
        w       = 1'b0;
        last_ev = now;
        #1;
        chk(name, {inPlay, newGame, paused, gameOver, winner}, 5'd0);
        step(2);
        chk({name, "_hold"}, {inPlay, newGame, paused, gameOver, winner}, 5'd0);
        resetn = 1'b1;
        step(3);
    endtask

    always @(negedge clock) begin
        if (mon_en) begin
            mon_v = {inPlay, newGame, paused, gameOver, winner};
            if (mon_v !== last_v) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_change got=%b at cycle %0d want=no change (%b)",
                             mon_v, cyc, last_v);
                end else begin
                    e = q.pop_front();
                    if (e.at != cyc || e.v !== mon_v) begin
                        failures++;
                        $display("FAIL output_event got=%b@%0d want=%b@%0d",
                                 mon_v, cyc, e.v, e.at);
                    end
                end
                last_v = mon_v;
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int iter;
        int r;
        int c0;

        step(3);
        chk("reset_inPlay",   {4'd0, inPlay},   5'd0);
        chk("reset_newGame",  {4'd0, newGame},  5'd0);
        chk("reset_paused",   {4'd0, paused},   5'd0);
        chk("reset_gameOver", {4'd0, gameOver}, 5'd0);
        chk("reset_winner",   {4'd0, winner},   5'd0);
        resetn = 1'b1;
        last_v = 5'd0;
        mon_en = 1'b1;
        step(3);

        for (int g = 0; g < 3; g++) begin
            if (g > 0 && $urandom_range(0, 1) == 1) press(1'b0, 1'b1, 2, 1'b0);
            press(1'b1, (g > 0) && ($urandom_range(0, 1) == 1),
                  (g == 0) ? 100 : $urandom_range(1, 40), g > 0);
            settle();
            iter = 0;
            while (mode != M_OVER && iter < 300) begin
                r = $urandom_range(0, 9);
                if (r < 2) begin
                    press(1'b0, 1'b1, $urandom_range(1, 4), 1'b0);
                    settle();
                    if ($urandom_range(0, 1) == 1) press(1'b1, 1'b0, 2, 1'b0);
                    press(1'b0, 1'b1, $urandom_range(1, 4), 1'b0);
                    settle();
                end else if (r == 2) begin
                    press(1'b1, 1'b0, $urandom_range(1, 10), 1'b0);
                    settle();
                end else begin
                    point($urandom_range(0, 1), $urandom_range(0, 2) == 0,
                          $urandom_range(0, 1) == 1);
                end
                iter++;
            end
        end

        c0 = now;
        press(1'b1, 1'b0, 2, 1'b1);
        while (now < c0 + 15) step(1);
        async_reset("reset_mid_serve");

        press(1'b1, 1'b0, 3, 1'b0);
        settle();
        step(2);
        async_reset("reset_mid_play");

        press(1'b1, 1'b0, 3, 1'b0);
        settle();
        point(1, 1'b1, 1'b0);
        step(5);

        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL pending_events got=%0d want=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
